// File: rtl/pc_stack_counter_pkg.sv
// Shared definitions for the stacked program counter: strobe decode and
// stack-pointer sizing.
package pc_stack_counter_pkg;

    localparam int BUS_W_DEF       = 8;
    localparam int WIDTH_DEF       = 4;
    localparam int STACK_DEPTH_DEF = 4;

    // Strobe priority, first match wins: J > JR > CALL > RET > CE.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_J,
        OP_JR,
        OP_CALL,
        OP_RET,
        OP_CE
    } pc_op_e;

    function automatic pc_op_e decode_op(input logic j, input logic jr,
                                         input logic call, input logic ret,
                                         input logic ce);
        pc_op_e op;
        op = OP_NONE;
        if (j)         op = OP_J;
        else if (jr)   op = OP_JR;
        else if (call) op = OP_CALL;
        else if (ret)  op = OP_RET;
        else if (ce)   op = OP_CE;
        return op;
    endfunction

    // Pointer must represent 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_stack_counter_if.sv
// One-hot control strobes from the control unit and the stack status
// flags returned by the program counter.
interface pc_stack_counter_if;

    logic J;
    logic JR;
    logic CALL;
    logic RET;
    logic CE;
    logic CO;
    logic stack_full;
    logic stack_empty;
    logic err;

    modport master (
        output J, JR, CALL, RET, CE, CO,
        input  stack_full, stack_empty, err
    );

    modport slave (
        input  J, JR, CALL, RET, CE, CO,
        output stack_full, stack_empty, err
    );

endinterface

// File: rtl/pc_stack_counter_lifo.sv
// Register-based return-address LIFO. A push when full or a pop when
// empty is ignored; only the pointer is reset.
module pc_stack_counter_lifo
    import pc_stack_counter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SP_W = sp_width(STACK_DEPTH);

    logic [SP_W-1:0]  sp_q;
    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // Entries are compared against the pointer rather than indexed by it,
    // so non-power-of-two depths never address past the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (do_push && (sp_q == SP_W'(i))) mem[i] <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) dout = mem[i];
        end
    end

endmodule

// File: rtl/pc_stack_counter.sv
// Parametrised program counter with absolute/relative jumps, a hardware
// call/return stack and a tri-state bus output.
module pc_stack_counter
    import pc_stack_counter_pkg::*;
#(
    parameter int BUS_W       = BUS_W_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire  [BUS_W-1:0]   bus,
    pc_stack_counter_if.slave  ctl
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] bus_lo;
    logic [WIDTH-1:0] ret_addr;
    logic             err_q;
    logic             err_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             bus_unused;
    pc_op_e           op;

    assign bus_lo     = bus[WIDTH-1:0];
    assign bus_unused = ^bus;
    assign pc_inc     = pc_q + WIDTH'(1);
    assign op         = decode_op(ctl.J, ctl.JR, ctl.CALL, ctl.RET, ctl.CE);
    assign push       = (op == OP_CALL);
    assign pop        = (op == OP_RET);

    pc_stack_counter_lifo #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .full  (full),
        .empty (empty)
    );

    // Relative jump: WIDTH-bit addition wraps mod 2^WIDTH, which is exactly
    // adding the sign-extended offset.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        case (op)
            OP_J:    pc_d = bus_lo;
            OP_JR:   pc_d = pc_q + bus_lo;
            OP_CALL: if (full) err_d = 1'b1; else pc_d = bus_lo;
            OP_RET:  if (empty) err_d = 1'b1; else pc_d = ret_addr;
            OP_CE:   pc_d = pc_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign bus             = ctl.CO ? BUS_W'(pc_q) : {BUS_W{1'bz}};
    assign ctl.stack_full  = full;
    assign ctl.stack_empty = empty;
    assign ctl.err         = err_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Bench for pc_stack_counter: directed vector table, multi-cycle reset
// sequences and randomized strobes against a queue-based reference model.
module tb_pc_stack_counter;

    localparam int BUS_W = 8;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [BUS_W-1:0] drv;
    logic             drv_en;
    wire  [BUS_W-1:0] bus;

    assign bus = drv_en ? drv : {BUS_W{1'bz}};

    pc_stack_counter_if ctl_if ();

    pc_stack_counter #(
        .BUS_W       (BUS_W),
        .WIDTH       (WIDTH),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .ctl (ctl_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: PC as an integer, return stack as a queue.
    int               pc_m;
    bit               err_m;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        bit         j;
        bit         jr;
        bit         call;
        bit         ret;
        bit         ce;
        logic [7:0] b;
        int         pc;
        bit         full;
        bit         empty;
        bit         err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit j, input bit jr, input bit call,
                           input bit ret, input bit ce, input logic [7:0] b,
                           input int pc, input bit full, input bit empty,
                           input bit err);
        vec_t v;
        v.j = j; v.jr = jr; v.call = call; v.ret = ret; v.ce = ce; v.b = b;
        v.pc = pc; v.full = full; v.empty = empty; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        pc_m  = 0;
        err_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit j, input bit jr, input bit call,
                              input bit ret, input bit ce, input logic [7:0] b);
        int lo;
        int off;
        lo = int'(b) % MOD;
        if (j) begin
            pc_m = lo;
        end else if (jr) begin
            off  = (lo >= MOD / 2) ? lo - MOD : lo;
            pc_m = ((pc_m + off) % MOD + MOD) % MOD;
        end else if (call) begin
            if (exp_q.size() == DEPTH) begin
                err_m = 1'b1;
            end else begin
                exp_q.push_back(WIDTH'((pc_m + 1) % MOD));
                pc_m = lo;
            end
        end else if (ret) begin
            if (exp_q.size() == 0) err_m = 1'b1;
            else pc_m = int'(exp_q.pop_back());
        end else if (ce) begin
            pc_m = (pc_m + 1) % MOD;
        end
    endtask

    task automatic chk(input string name, input logic [BUS_W-1:0] act,
                       input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_strobes(input bit j, input bit jr, input bit call,
                               input bit ret, input bit ce);
        ctl_if.J    = j;
        ctl_if.JR   = jr;
        ctl_if.CALL = call;
        ctl_if.RET  = ret;
        ctl_if.CE   = ce;
    endtask

    // Drive one strobe cycle with the bench sourcing the bus.
    task automatic apply(input bit j, input bit jr, input bit call,
                         input bit ret, input bit ce, input logic [7:0] b);
        ctl_if.CO = 1'b0;
        drv_en    = 1'b1;
        drv       = b;
        set_strobes(j, jr, call, ret, ce);
        @(posedge clk);
        #1;
        set_strobes(0, 0, 0, 0, 0);
        drv_en = 1'b0;
        model_step(j, jr, call, ret, ce, b);
    endtask

    // Reads the PC through the bus with CO=1 and compares status flags.
    task automatic check_state(input string name, input int pc, input bit full,
                               input bit empty, input bit err);
        drv_en    = 1'b0;
        ctl_if.CO = 1'b1;
        #1;
        chk({name, ".pc"},    bus, BUS_W'(pc));
        chk({name, ".full"},  BUS_W'(ctl_if.stack_full),  BUS_W'(full));
        chk({name, ".empty"}, BUS_W'(ctl_if.stack_empty), BUS_W'(empty));
        chk({name, ".err"},   BUS_W'(ctl_if.err),         BUS_W'(err));
        ctl_if.CO = 1'b0;
    endtask

    task automatic check_model(input string name);
        check_state(name, pc_m, exp_q.size() == DEPTH, exp_q.size() == 0, err_m);
    endtask

    initial begin
        bit j, jr, call, ret, ce;
        int r;

        rst       = 1'b0;
        drv       = '0;
        drv_en    = 1'b0;
        ctl_if.CO = 1'b0;
        set_strobes(0, 0, 0, 0, 0);
        model_reset();

        // CO during reset shows the cleared PC.
        #2;
        check_state("reset", 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;

        // 17 counts wrap 15 -> 0 and end at 1.
        for (int i = 1; i <= 17; i++) begin
            apply(0, 0, 0, 0, 1, 8'h00);
            if (i >= 15) check_state($sformatf("ce%0d", i), i % MOD, 0, 1, 0);
        end

        // With CO=0 the bench's pattern must read back unaltered.
        ctl_if.CO = 1'b0;
        drv_en    = 1'b1;
        drv       = 8'h50;
        #1;
        chk("hiz", bus, 8'h50);
        drv_en = 1'b0;

        //      j  jr call ret ce bus     pc  full empty err
        add_vec(1, 0, 0, 0, 0, 8'h05,  5, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 8'hFE,  3, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 8'h07, 10, 0, 1, 0);
        add_vec(1, 0, 0, 0, 0, 8'h0E, 14, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 8'h03,  1, 0, 1, 0);
        add_vec(1, 0, 0, 0, 0, 8'hF2,  2, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0, 8'h09,  9, 0, 0, 0);
        add_vec(0, 0, 0, 1, 0, 8'h00,  3, 0, 1, 0);
        add_vec(0, 0, 0, 0, 1, 8'h00,  4, 0, 1, 0);
        add_vec(1, 0, 1, 0, 1, 8'h0A, 10, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0, 8'h01,  1, 0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 8'h02,  2, 0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 8'h03,  3, 0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 8'h04,  4, 1, 0, 0);
        add_vec(0, 0, 1, 0, 0, 8'h0C,  4, 1, 0, 1);
        add_vec(0, 1, 1, 1, 0, 8'h01,  5, 1, 0, 1);
        add_vec(0, 0, 0, 1, 0, 8'h00,  4, 0, 0, 1);
        add_vec(0, 0, 0, 1, 0, 8'h00,  3, 0, 0, 1);
        add_vec(0, 0, 0, 1, 0, 8'h00,  2, 0, 0, 1);
        add_vec(0, 0, 0, 1, 0, 8'h00, 11, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1, 8'h00, 11, 0, 1, 1);
        add_vec(0, 0, 0, 0, 1, 8'h00, 12, 0, 1, 1);

        foreach (vecs[k]) begin
            apply(vecs[k].j, vecs[k].jr, vecs[k].call, vecs[k].ret, vecs[k].ce, vecs[k].b);
            check_state($sformatf("vec%0d", k), vecs[k].pc, vecs[k].full,
                        vecs[k].empty, vecs[k].err);
        end

        // Asynchronous reset clears everything before any clock edge.
        rst = 1'b0;
        model_reset();
        #1;
        check_state("async_rst", 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Underflow sets err, which then survives normal operation.
        apply(1, 0, 0, 0, 0, 8'h06);
        apply(0, 0, 0, 1, 0, 8'h00);
        check_state("ret_empty", 6, 0, 1, 1);
        apply(0, 0, 0, 0, 1, 8'h00);
        check_state("err_sticky", 7, 0, 1, 1);
        rst = 1'b0;
        model_reset();
        #1;
        check_state("err_clear", 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted while a CALL is pending leaves no pushed entry.
        apply(1, 0, 0, 0, 0, 8'h03);
        drv_en = 1'b1;
        drv    = 8'h05;
        set_strobes(0, 0, 1, 0, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_strobes(0, 0, 0, 0, 0);
        drv_en = 1'b0;
        model_reset();
        check_state("rst_mid_call", 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_state("rst_mid_call_rel", 0, 0, 1, 0);

        // Randomized strobes against the reference model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_model($sformatf("rnd_rst%0d", n));
                @(negedge clk);
                rst = 1'b1;
                continue;
            end
            j    = ($urandom_range(0, 9) == 0);
            jr   = ($urandom_range(0, 7) == 0);
            call = ($urandom_range(0, 2) == 0);
            ret  = ($urandom_range(0, 2) == 0);
            ce   = ($urandom_range(0, 1) == 0);
            apply(j, jr, call, ret, ce, 8'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_counter.md
Name: pc_stack_counter

Overview:
- Parametrised program counter for the 8-bit bus CPU.
- Generalises the 4-bit counter to WIDTH bits and adds a bus-relative jump.
- Adds a hardware call/return stack of STACK_DEPTH entries, with full/empty status and a sticky error flag.
- Sits on the shared tri-state bus; sequenced by the control unit through one-hot control strobes.

Parameters:
- BUS_W, 8, width of the shared bus.
- WIDTH, 4, PC width; legal range 1 ≤ WIDTH ≤ BUS_W.
- STACK_DEPTH, 4, number of return-address entries; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-low.
- bus  inout  BUS_W  shared bus; source for jump targets and offsets; destination for PC output.
- CE  input  1  count enable.
- J  input  1  absolute jump: PC <= bus[WIDTH-1:0].
- JR  input  1  relative jump: PC <= PC + sign-extended bus offset.
- CALL  input  1  push PC+1, then PC <= bus[WIDTH-1:0].
- RET  input  1  pop stack top into PC.
- CO  input  1  counter out: drive PC onto bus.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- err  output  1  sticky flag: overflow or underflow occurred.

Behaviour:
- Reset (rst low, asynchronous):
  - PC=0, stack pointer=0, err=0.
  - stack_full=0, stack_empty=1.
  - Stack entry contents are don't-care.
  - CO still controls bus drive during reset; if CO=1, the bus reads 0.
- Bus drive (combinational):
  - CO=1: bus = PC zero-extended to BUS_W.
  - CO=0: all BUS_W bits are high-Z.
- Update priority (rising edge, rst high), first match wins:
  - J > JR > CALL > RET > CE.
  - Lower-priority strobes asserted in the same cycle are ignored; none of their side effects occur (no push, no pop, no err).
- J: PC <= bus[WIDTH-1:0]. Upper bus bits are ignored.
- JR:
  - Offset = bus[WIDTH-1:0] interpreted as two's complement.
  - PC <= (PC + offset) mod 2^WIDTH.
  - Upper bus bits are ignored.
- CALL when not full:
  - stack[sp] <= (PC+1) mod 2^WIDTH; sp <= sp+1.
  - PC <= bus[WIDTH-1:0].
- CALL when full:
  - No push; PC unchanged; err <= 1.
- RET when not empty:
  - sp <= sp-1; PC <= stack[sp-1].
- RET when empty:
  - PC unchanged; err <= 1.
- CE: PC <= PC+1, wrapping 2^WIDTH-1 → 0.
- No strobe: all state holds.
- Status flags:
  - stack_full and stack_empty are registered and reflect sp after the edge.
  - Latency: status updates 1 cycle after the strobe; the new PC is visible on the bus in the cycle after the edge when CO=1.
- err: cleared only by rst.
- CO combined with a bus-sourcing strobe (J, JR, CALL):
  - The control unit never asserts this combination.
  - The formal harness constrains against it.
  - RTL behaviour for it is unspecified.
- Reset mid-CALL/RET (rst falling during the cycle): reset wins immediately; no partial push or pop persists.
- Formal properties:
  - Bus is high-Z whenever CO=0.
  - sp ≤ STACK_DEPTH at all times.
  - stack_full == (sp == STACK_DEPTH).
  - stack_empty == (sp == 0).
  - err never falls while rst is high.

Decomposition:
- Shared header pc_defs.vh holds:
  - Priority order documentation.
  - Localparam SP_W = clog2(STACK_DEPTH+1).
  - No typedefs (plain Verilog).
- Sub-module pc_lifo:
  - Parametrised WIDTH × STACK_DEPTH register LIFO.
  - push/pop inputs with data in/out, full/empty outputs.
  - Overflow/underflow protection, async active-low reset on the pointer.
- Top level holds:
  - PC register.
  - Priority decode.
  - Relative adder.
  - Bus tri-state.
  - err register.

Test Plan:
- Reset, then CE for 17 cycles with WIDTH=4 → PC counts 0..15, wraps to 0, ends at 1. CO=1 shows bus=8'h01; CO=0 shows 8'hzz.
- PC=5, bus=8'hFE, JR=1 (offset -2) → PC=3. Then bus=8'h07, JR=1 → PC=10. Then PC=14, bus=8'h03, JR → PC=1 (wrap).
- PC=2, CALL with bus=8'h09 → PC=9, stack_empty=0. Then RET → PC=3, stack_empty=1, err=0.
- DEPTH=4: four CALLs succeed and stack_full=1. Fifth CALL (bus=8'h0C) → PC unchanged, err=1, stack_full stays 1. Four RETs return the addresses in reverse order.
- RET on empty stack with PC=6 → PC=6, err=1. Then CE → PC=7, err stays 1. Then rst low → PC=0, err=0, stack_empty=1 asynchronously (before the next clk edge).
- J=1, CE=1, CALL=1 simultaneously with bus=8'h0A, PC=4 → PC=10, no push (stack_empty stays 1), err=0.
